// File: rtl/multicycle_addsub_nbit.sv
// multicycle_addsub_nbit
//   Serial (digit-at-a-time) adder/subtractor. An operation is accepted in
//   IDLE, processed DIGIT bits per cycle for NUM_BIT/DIGIT cycles in BUSY,
//   and presented in DONE until the consumer takes it.
//
// Parameters
//   NUM_BIT   operand/result width (integer multiple of DIGIT)
//   DIGIT     bits processed per BUSY cycle (1..NUM_BIT)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   a, b, cin, mode   operands; mode 0 = a - b - cin, mode 1 = a + b + cin
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   res, cout, ovf    result, carry/borrow out, signed overflow
module multicycle_addsub_nbit #(
  parameter int NUM_BIT = 8,
  parameter int DIGIT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_BIT-1:0] a,
  input  logic [NUM_BIT-1:0] b,
  input  logic               cin,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_BIT-1:0] res,
  output logic               cout,
  output logic               ovf
);

  localparam int STEPS = NUM_BIT / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_BIT-1:0] a_q, a_d;
  logic [NUM_BIT-1:0] b_q, b_d;
  logic [NUM_BIT-1:0] res_q, res_d;
  logic               mode_q, mode_d;
  logic               chain_q, chain_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;

  logic [DIGIT:0]     dsum;
  logic [NUM_BIT-1:0] res_next;
  logic               last_step;

  // Subtraction runs on the same adder as a + ~b + ~cin: the chain then
  // carries "not borrow", so borrow-out is the inverted final carry, and the
  // signed-overflow rule for addition applies to the effective operands.
  always_comb begin
    dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, chain_q};
    res_next  = NUM_BIT'({dsum[DIGIT-1:0], res_q} >> DIGIT);
    last_step = (cnt_q == CW'(STEPS - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    mode_d  = mode_q;
    chain_d = chain_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = mode ? b : ~b;
          mode_d  = mode;
          chain_d = mode ? cin : ~cin;
          sa_d    = a[NUM_BIT-1];
          sb_d    = mode ? b[NUM_BIT-1] : ~b[NUM_BIT-1];
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        res_d   = res_next;
        chain_d = dsum[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          cnt_d   = '0;
          cout_d  = mode_q ? dsum[DIGIT] : ~dsum[DIGIT];
          ovf_d   = (sa_q == sb_q) && (res_next[NUM_BIT-1] != sa_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      chain_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      chain_q <= chain_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_addsub_nbit.sv
// Bench for multicycle_addsub_nbit: unit 0 is NUM_BIT=8/DIGIT=2, unit 1 is
// NUM_BIT=8/DIGIT=8. An arithmetic reference model predicts every result.
module tb_multicycle_addsub_nbit;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  logic         in_valid[2], in_ready[2], cin[2], mode[2];
  logic         out_valid[2], out_ready[2], cout[2], ovf[2];
  logic [N-1:0] a[2], b[2], res[2];

  always #5 clk = ~clk;

  multicycle_addsub_nbit #(.NUM_BIT(N), .DIGIT(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .mode(mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .res(res[0]), .cout(cout[0]), .ovf(ovf[0]));

  multicycle_addsub_nbit #(.NUM_BIT(N), .DIGIT(N)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .mode(mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .res(res[1]), .cout(cout[1]), .ovf(ovf[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic with plain integers.
  function automatic void ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic c, input logic m,
                                 output logic [N-1:0] r, output logic co, output logic ov);
    int ux, uy, sx, sy, ci, uexact, exact;
    ux = int'(x);
    uy = int'(y);
    ci = c ? 1 : 0;
    sx = (ux >= (1 << (N-1))) ? ux - (1 << N) : ux;
    sy = (uy >= (1 << (N-1))) ? uy - (1 << N) : uy;
    if (m) begin
      uexact = ux + uy + ci;
      co     = (uexact >= (1 << N));
      exact  = sx + sy + ci;
    end else begin
      uexact = ux - uy - ci;
      co     = (ux < uy + ci);
      exact  = sx - sy - ci;
    end
    r  = uexact[N-1:0];
    ov = (exact < -(1 << (N-1))) || (exact > (1 << (N-1)) - 1);
  endfunction

  // Behavioural model: phase 0 idle, 1 busy, 2 done.
  int           phase[2] = '{0, 0};
  int           left[2]  = '{0, 0};
  int           steps[2] = '{4, 1};
  logic [N-1:0] e_res[2] = '{8'd0, 8'd0};
  logic         e_co[2]  = '{1'b0, 1'b0};
  logic         e_ov[2]  = '{1'b0, 1'b0};
  logic [N-1:0] p_res[2];
  logic         p_co[2], p_ov[2];
  logic [N-1:0] m_r;
  logic         m_c, m_o;

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        phase[u] = 0;
        e_res[u] = '0;
        e_co[u]  = 1'b0;
        e_ov[u]  = 1'b0;
      end else begin
        case (phase[u])
          0: if (in_valid[u]) begin
               ref_op(a[u], b[u], cin[u], mode[u], m_r, m_c, m_o);
               p_res[u] = m_r;
               p_co[u]  = m_c;
               p_ov[u]  = m_o;
               left[u]  = steps[u];
               phase[u] = 1;
             end
          1: begin
               left[u] = left[u] - 1;
               if (left[u] == 0) begin
                 phase[u] = 2;
                 e_res[u] = p_res[u];
                 e_co[u]  = p_co[u];
                 e_ov[u]  = p_ov[u];
               end
             end
          default: if (out_ready[u]) phase[u] = 0;
        endcase
      end
    end
  end

  // Compare process: handshakes every cycle, result fields whenever not busy.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_in_ready", u), in_ready[u], phase[u] == 0);
      chk($sformatf("u%0d_out_valid", u), out_valid[u], phase[u] == 2);
      if (phase[u] != 1) begin
        chk($sformatf("u%0d_res", u), res[u], e_res[u]);
        chk($sformatf("u%0d_cout", u), cout[u], e_co[u]);
        chk($sformatf("u%0d_ovf", u), ovf[u], e_ov[u]);
      end
    end
  end

  task automatic issue(input int u, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic c, input logic m);
    int t;
    t = 0;
    while (!in_ready[u] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_ready", in_ready[u], 1);
    a[u] = x; b[u] = y; cin[u] = c; mode[u] = m;
    in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, output int lat);
    lat = 0;
    while (!out_valid[u] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic directed(input string nm, input int u,
                          input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic c, input logic m,
                          input logic [N-1:0] er, input logic ec, input logic eo,
                          input int el);
    int lat;
    issue(u, x, y, c, m);
    wait_valid(u, lat);
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_res"}, res[u], er);
    chk({nm, "_cout"}, cout[u], ec);
    chk({nm, "_ovf"}, ovf[u], eo);
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [N-1:0] rx, ry;
    logic rc, rm;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; out_ready[u] = 1'b1;
      a[u] = '0; b[u] = '0; cin[u] = 1'b0; mode[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res", res[0], 0);
    chk("reset_in_ready", in_ready[0], 1);
    chk("reset_out_valid", out_valid[0], 0);
    chk("reset_cout", cout[0], 0);
    chk("reset_ovf", ovf[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    directed("sub_100_37", 0, 8'd100, 8'd37, 1'b0, 1'b0, 8'd63, 1'b0, 1'b0, 4);
    directed("sub_5_10_c1", 0, 8'd5, 8'd10, 1'b1, 1'b0, 8'd250, 1'b1, 1'b0, 4);
    directed("sub_80_1", 0, 8'h80, 8'd1, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 4);
    directed("add_200_100_c1", 0, 8'd200, 8'd100, 1'b1, 1'b1, 8'd45, 1'b1, 1'b0, 4);
    directed("add_127_1", 0, 8'd127, 8'd1, 1'b0, 1'b1, 8'd128, 1'b0, 1'b1, 4);
    directed("sub_0_7f_c1", 0, 8'd0, 8'h7F, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 4);
    directed("d8_sub_3_4", 1, 8'd3, 8'd4, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1);
    directed("d8_add_ff_ff_c1", 1, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1);

    // Stall in DONE while offering new operands that must be ignored.
    out_ready[0] = 1'b0;
    issue(0, 8'd50, 8'd20, 1'b0, 1'b1);
    wait_valid(0, lat);
    chk("hold_latency", lat, 4);
    for (int i = 0; i < 3; i++) begin
      a[0] = 8'hAA; b[0] = 8'h11; cin[0] = 1'b1; mode[0] = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid[0], 1);
      chk("hold_in_ready", in_ready[0], 0);
      chk("hold_res", res[0], 70);
      chk("hold_cout", cout[0], 0);
      chk("hold_ovf", ovf[0], 0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", out_valid[0], 0);
    chk("release_in_ready", in_ready[0], 1);
    chk("release_res", res[0], 70);
    repeat (2) @(posedge clk);
    #1;
    chk("release_still_idle", in_ready[0], 1);

    // Reset during the second BUSY cycle.
    issue(0, 8'd100, 8'd37, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid[0], 0);
    chk("abort_in_ready", in_ready[0], 1);
    chk("abort_res", res[0], 0);
    directed("after_abort_9_4", 0, 8'd9, 8'd4, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 4);

    // Random regression in both modes with occasional consumer stalls.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < ((u == 0) ? 1000 : 300); i++) begin
        rx = N'($urandom); ry = N'($urandom);
        rc = 1'($urandom); rm = 1'($urandom);
        out_ready[u] = ($urandom_range(0, 3) != 0);
        issue(u, rx, ry, rc, rm);
        wait_valid(u, lat);
        chk("rand_latency", lat, steps[u]);
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
